// File: rtl/rv32i_defs.sv
// Shared RV32I definitions for the register-file writeback path.
// Holds the load funct3 encodings, the writeback FSM state type and
// a helper that decides whether a load width/offset pair is legal.
package rv32i_defs;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_t;

   // A load is legal when funct3 names a real load width and the byte
   // offset is naturally aligned for that width.
   function automatic logic load_ok(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         F3_LB, F3_LBU: ok = 1'b1;
         F3_LH, F3_LHU: ok = ~addr_lo[0];
         F3_LW:         ok = (addr_lo == 2'b00);
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_writeback_unit_if.sv
// Bundle of the three channels around the writeback unit:
//   req_*     : retiring-instruction request (valid/ready)
//   mem_rd_*  : memory read data return (valid/ready)
//   wr_*      : register file write port
// master = environment side (pipeline + memory + regfile observer),
// slave  = the writeback unit itself.
interface load_writeback_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_load;
   logic [4:0]  req_rd;
   logic [2:0]  req_funct3;
   logic [1:0]  req_addr_lo;
   logic [31:0] req_alu_result;

   logic        mem_rd_valid;
   logic        mem_rd_ready;
   logic [31:0] mem_rd_data;

   logic        wr_ena;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   modport master (
      output req_valid, req_is_load, req_rd, req_funct3, req_addr_lo, req_alu_result,
      input  req_ready,
      output mem_rd_valid, mem_rd_data,
      input  mem_rd_ready,
      input  wr_ena, wr_addr, wr_data
   );

   modport slave (
      input  req_valid, req_is_load, req_rd, req_funct3, req_addr_lo, req_alu_result,
      output req_ready,
      input  mem_rd_valid, mem_rd_data,
      output mem_rd_ready,
      output wr_ena, wr_addr, wr_data
   );
endinterface

// File: rtl/load_extender.sv
// Combinational load data extractor.
// Ports:
//   funct3  : load width/sign encoding
//   addr_lo : byte offset within the aligned word
//   word    : aligned 32-bit memory word
//   value   : selected byte/half/word, sign- or zero-extended to 32 bits
module load_extender
   import rv32i_defs::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  value = {24'h0, byte_sel};
         F3_LH:   value = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  value = {16'h0, half_sel};
         F3_LW:   value = word;
         default: value = word;
      endcase
   end

endmodule

// File: rtl/load_writeback_unit.sv
// Register-file write-port driver for RV32I. Accepts one retiring
// instruction per request: ALU results go straight to a write pulse,
// loads wait for memory data, extract/extend it, then write.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : request, memory-return and regfile-write channels (slave side)
//   busy : unit is not idle
//   err  : one-cycle pulse for illegal/misaligned load or memory timeout
module load_writeback_unit
   import rv32i_defs::*;
#(
   parameter  int MEM_TIMEOUT = 16,
   localparam int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   load_writeback_unit_if.slave bus,
   output logic                 busy,
   output logic                 err
);

   wb_state_t         state_reg;
   logic [TMO_W-1:0]  cnt_reg;
   logic [4:0]        rd_reg;
   logic [2:0]        funct3_reg;
   logic [1:0]        addr_lo_reg;
   logic              wr_ena_reg;
   logic [4:0]        wr_addr_reg;
   logic [31:0]       wr_data_reg;
   logic              err_reg;
   logic [31:0]       ext_value;

   load_extender u_ext (
      .funct3  (funct3_reg),
      .addr_lo (addr_lo_reg),
      .word    (bus.mem_rd_data),
      .value   (ext_value)
   );

   // Handshake readies are gated by rst so nothing is accepted while
   // reset is being held, even though state already reads IDLE.
   assign bus.req_ready    = rst && (state_reg == IDLE);
   assign bus.mem_rd_ready = rst && (state_reg == WAIT_MEM);
   assign bus.wr_ena       = wr_ena_reg;
   assign bus.wr_addr      = wr_addr_reg;
   assign bus.wr_data      = wr_data_reg;
   assign busy             = (state_reg != IDLE);
   assign err              = err_reg;

   // The write port is loaded on the same edge that enters WRITE, so
   // the pulse is visible during the WRITE cycle itself.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         rd_reg      <= '0;
         funct3_reg  <= '0;
         addr_lo_reg <= '0;
         wr_ena_reg  <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         wr_ena_reg <= 1'b0;
         err_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.req_valid) begin
                  rd_reg      <= bus.req_rd;
                  funct3_reg  <= bus.req_funct3;
                  addr_lo_reg <= bus.req_addr_lo;
                  if (!bus.req_is_load) begin
                     wr_ena_reg  <= (bus.req_rd != 5'd0);
                     wr_addr_reg <= bus.req_rd;
                     wr_data_reg <= bus.req_alu_result;
                     state_reg   <= WRITE;
                  end else if (load_ok(bus.req_funct3, bus.req_addr_lo)) begin
                     cnt_reg   <= '0;
                     state_reg <= WAIT_MEM;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            WAIT_MEM: begin
               // Data on the expiry cycle takes priority over the abort.
               if (bus.mem_rd_valid) begin
                  wr_ena_reg  <= (rd_reg != 5'd0);
                  wr_addr_reg <= rd_reg;
                  wr_data_reg <= ext_value;
                  state_reg   <= WRITE;
               end else if (cnt_reg == TMO_W'(MEM_TIMEOUT - 1)) begin
                  err_reg   <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            WRITE:   state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_writeback_unit.sv
module tb_load_writeback_unit;
   import rv32i_defs::*;

   localparam int MT = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic err;

   load_writeback_unit_if ifc();

   load_writeback_unit #(.MEM_TIMEOUT(MT)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (ifc.slave),
      .busy (busy),
      .err  (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_err;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Scoreboard monitor: every write pulse or err pulse pops one entry.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (ifc.wr_ena || err) begin
            checks++;
            if (ifc.wr_ena && err) begin
               errors++;
               $display("FAIL wr_err_overlap: wr_ena=1 err=1, required never both");
            end
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: wr_ena=%0b err=%0b addr=%0d data=%h, required no event",
                        ifc.wr_ena, err, ifc.wr_addr, ifc.wr_data);
            end else begin
               e = sb.pop_front();
               if (e.is_err) begin
                  if (err !== 1'b1 || ifc.wr_ena !== 1'b0) begin
                     errors++;
                     $display("FAIL sb_err: err=%0b wr_ena=%0b, required err=1 wr_ena=0", err, ifc.wr_ena);
                  end else
                     $display("[%0t] err pulse", $time);
               end else begin
                  if (ifc.wr_ena !== 1'b1 || ifc.wr_addr !== e.addr || ifc.wr_data !== e.data) begin
                     errors++;
                     $display("FAIL sb_write: wr_ena=%0b addr=%0d data=%h, required wr_ena=1 addr=%0d data=%h",
                              ifc.wr_ena, ifc.wr_addr, ifc.wr_data, e.addr, e.data);
                  end else
                     $display("[%0t] write x%0d <= %h", $time, e.addr, e.data);
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_write(input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e.is_err = 1'b0; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1; e.addr = '0; e.data = '0;
      sb.push_back(e);
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic send_req(input logic is_load, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] alu, output longint t_acc);
      int n = 0;
      ifc.req_valid = 1'b1; ifc.req_is_load = is_load; ifc.req_rd = rd;
      ifc.req_funct3 = f3; ifc.req_addr_lo = off; ifc.req_alu_result = alu;
      while (ifc.req_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL req_accept_timeout: req_ready=%0b, required 1 within 50 cycles", ifc.req_ready);
      end
      @(posedge clk);
      t_acc = $time;
      #1;
      ifc.req_valid = 1'b0;
   endtask

   task automatic mem_resp(input logic [31:0] data, input int delay);
      int n = 0;
      repeat (delay) step();
      ifc.mem_rd_valid = 1'b1; ifc.mem_rd_data = data;
      while (ifc.mem_rd_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL mem_ready_timeout: mem_rd_ready=%0b, required 1", ifc.mem_rd_ready);
      end
      step();
      ifc.mem_rd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout: busy=%0b, required 0", busy);
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d events pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ifc.req_valid = 0; ifc.req_is_load = 0; ifc.req_rd = 0; ifc.req_funct3 = 0;
      ifc.req_addr_lo = 0; ifc.req_alu_result = 0; ifc.mem_rd_valid = 0; ifc.mem_rd_data = 0;
      step(); step();
      checks++;
      if (ifc.wr_ena !== 1'b0 || ifc.wr_addr !== 5'd0 || ifc.wr_data !== 32'd0 || err !== 1'b0 ||
          busy !== 1'b0 || ifc.req_ready !== 1'b0 || ifc.mem_rd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: wr_ena=%0b addr=%0d data=%h err=%0b busy=%0b req_ready=%0b mem_rd_ready=%0b, required all 0",
                  ifc.wr_ena, ifc.wr_addr, ifc.wr_data, err, busy, ifc.req_ready, ifc.mem_rd_ready);
      end
      rst = 1'b1;
      step();
      checks++;
      if (ifc.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: req_ready=%0b, required 1", ifc.req_ready);
      end
   endtask

   task automatic test_alu();
      longint t;
      push_write(5'd5, 32'hDEADBEEF);
      send_req(1'b0, 5'd5, 3'b000, 2'b00, 32'hDEADBEEF, t);
      checks++;
      if (ifc.wr_ena !== 1'b1 || ifc.wr_addr !== 5'd5 || ifc.wr_data !== 32'hDEADBEEF || ifc.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL alu_write_cycle: wr_ena=%0b addr=%0d data=%h req_ready=%0b, required 1/5/deadbeef/0",
                  ifc.wr_ena, ifc.wr_addr, ifc.wr_data, ifc.req_ready);
      end
      step();
      checks++;
      if (ifc.wr_ena !== 1'b0 || ifc.req_ready !== 1'b1 || ifc.wr_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL alu_after_write: wr_ena=%0b req_ready=%0b data=%h, required 0/1/deadbeef",
                  ifc.wr_ena, ifc.req_ready, ifc.wr_data);
      end
      check_drained("alu");
   endtask

   task automatic test_x0();
      longint t;
      send_req(1'b0, 5'd0, 3'b000, 2'b00, 32'h12345678, t);
      checks++;
      if (ifc.wr_ena !== 1'b0 || busy !== 1'b1 || ifc.wr_addr !== 5'd0 || ifc.wr_data !== 32'h12345678) begin
         errors++;
         $display("FAIL x0_write_cycle: wr_ena=%0b busy=%0b addr=%0d data=%h, required 0/1/0/12345678",
                  ifc.wr_ena, busy, ifc.wr_addr, ifc.wr_data);
      end
      step();
      checks++;
      if (ifc.wr_ena !== 1'b0 || err !== 1'b0 || ifc.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_after: wr_ena=%0b err=%0b req_ready=%0b, required 0/0/1", ifc.wr_ena, err, ifc.req_ready);
      end
      check_drained("x0");
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3_t  [6] = '{F3_LB, F3_LBU, F3_LB, F3_LH, F3_LHU, F3_LW};
      logic [1:0]  off_t [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
      logic [31:0] exp_t_v [6] = '{32'hFFFFFF82, 32'h00000082, 32'h0000007F,
                                   32'hFFFF80F1, 32'h000080F1, 32'h80F17F82};
      longint t;
      for (int i = 0; i < 6; i++) begin
         push_write(5'd10, exp_t_v[i]);
         send_req(1'b1, 5'd10, f3_t[i], off_t[i], 32'hA5A5A5A5, t);
         mem_resp(32'h80F17F82, $urandom_range(0, 3));
         wait_idle();
      end
      check_drained("load_ext");
   endtask

   task automatic test_misaligned();
      logic [2:0] f3_t  [3] = '{F3_LW, F3_LH, 3'b011};
      logic [1:0] off_t [3] = '{2'd2, 2'd1, 2'd0};
      longint t;
      for (int i = 0; i < 3; i++) begin
         push_err();
         send_req(1'b1, 5'd3, f3_t[i], off_t[i], 32'h0, t);
         checks++;
         if (err !== 1'b1 || ifc.wr_ena !== 1'b0 || busy !== 1'b0 || ifc.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_%0d: err=%0b wr_ena=%0b busy=%0b req_ready=%0b, required 1/0/0/1",
                     i, err, ifc.wr_ena, busy, ifc.req_ready);
         end
         step();
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_pulse_%0d: err=%0b, required 0 after one cycle", i, err);
         end
      end
      check_drained("misaligned");
   endtask

   task automatic test_timeout();
      longint t;
      push_err();
      send_req(1'b1, 5'd4, F3_LW, 2'd0, 32'h0, t);
      repeat (MT - 1) step();
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: err=%0b busy=%0b, required 0/1", err, busy);
      end
      step();
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || ifc.wr_ena !== 1'b0) begin
         errors++;
         $display("FAIL timeout_expiry: err=%0b busy=%0b wr_ena=%0b, required 1/0/0", err, busy, ifc.wr_ena);
      end
      step();
      check_drained("timeout");
      // Data arriving on the expiry cycle must win.
      push_write(5'd7, 32'h11223344);
      send_req(1'b1, 5'd7, F3_LW, 2'd0, 32'h0, t);
      repeat (MT - 1) step();
      ifc.mem_rd_valid = 1'b1; ifc.mem_rd_data = 32'h11223344;
      step();
      ifc.mem_rd_valid = 1'b0;
      checks++;
      if (err !== 1'b0 || ifc.wr_ena !== 1'b1 || ifc.wr_data !== 32'h11223344) begin
         errors++;
         $display("FAIL timeout_data_wins: err=%0b wr_ena=%0b data=%h, required 0/1/11223344",
                  err, ifc.wr_ena, ifc.wr_data);
      end
      wait_idle();
      check_drained("timeout_data");
   endtask

   task automatic test_back_to_back();
      longint t, t_prev;
      logic [31:0] v;
      t_prev = 0;
      for (int i = 1; i <= 4; i++) begin
         v = $urandom();
         push_write(5'(i), v);
         send_req(1'b0, 5'(i), 3'b000, 2'b00, v, t);
         if (i > 1) begin
            checks++;
            if (t - t_prev != 20) begin
               errors++;
               $display("FAIL b2b_spacing_%0d: %0d ns between accepts, required 20", i, t - t_prev);
            end
         end
         t_prev = t;
      end
      wait_idle();
      check_drained("b2b");
   endtask

   task automatic test_reset_mid_load();
      longint t;
      send_req(1'b1, 5'd9, F3_LW, 2'd0, 32'h0, t);
      step();
      rst = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || ifc.req_ready !== 1'b0 || ifc.mem_rd_ready !== 1'b0 ||
          ifc.wr_addr !== 5'd0 || ifc.wr_data !== 32'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_held: busy=%0b req_ready=%0b mem_rd_ready=%0b addr=%0d data=%h err=%0b, required all 0",
                  busy, ifc.req_ready, ifc.mem_rd_ready, ifc.wr_addr, ifc.wr_data, err);
      end
      rst = 1'b1;
      ifc.mem_rd_valid = 1'b1; ifc.mem_rd_data = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ifc.wr_ena !== 1'b0 || busy !== 1'b0 || ifc.mem_rd_ready !== 1'b0 || ifc.wr_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_after_%0d: wr_ena=%0b busy=%0b mem_rd_ready=%0b data=%h, required 0/0/0/0",
                     i, ifc.wr_ena, busy, ifc.mem_rd_ready, ifc.wr_data);
         end
      end
      ifc.mem_rd_valid = 1'b0;
      check_drained("midreset");
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_alu();
      test_x0();
      test_load_ext();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_reset_mid_load();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "global timeout");
   end

endmodule
